// File: rtl/fb_stream_loader.sv
// fb_stream_loader: AXI-Stream slave that writes one frame of beats into framebuffer RAM,
// checking tlast framing and discarding surplus beats after a missing tlast.
module fb_stream_loader #(
    parameter int FRAME_SIZE           = 128*128,
    parameter int STREAM_WIDTH         = 16,
    parameter int NUMBER_OF_SUB_PIXELS = 4,
    parameter int SUB_PIXEL_WIDTH      = 4,
    localparam int PIXEL_WIDTH    = NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH,
    localparam int PIXEL_PER_BEAT = STREAM_WIDTH/PIXEL_WIDTH,
    localparam int BEATS          = FRAME_SIZE/PIXEL_PER_BEAT,
    localparam int MEM_ADDR_WIDTH = $clog2(BEATS),
    localparam int STROBES        = STREAM_WIDTH/SUB_PIXEL_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            apply,
    output logic                            applied,
    input  logic                            cmdLoad,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] loadMask,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]         s_axis_tdata,
    output logic                            memWrite,
    output logic [MEM_ADDR_WIDTH-1:0]       memWriteAddr,
    output logic [STREAM_WIDTH-1:0]         memWriteData,
    output logic [STROBES-1:0]              memWriteMask,
    output logic                            errTlastEarly,
    output logic                            errTlastMissing
);
    typedef enum logic [1:0] {IDLE, LOAD, DISCARD} state_t;

    localparam logic [MEM_ADDR_WIDTH:0] LAST = (MEM_ADDR_WIDTH+1)'(BEATS-1);

    state_t                          state_q, state_d;
    logic [MEM_ADDR_WIDTH:0]         cnt_q, cnt_d;
    logic [NUMBER_OF_SUB_PIXELS-1:0] mask_q, mask_d;
    logic                            ready_q, ready_d;
    logic                            applied_q, applied_d;
    logic                            we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [STREAM_WIDTH-1:0]         data_q, data_d;
    logic [STROBES-1:0]              wmask_q, wmask_d;
    logic                            early_q, early_d;
    logic                            miss_q, miss_d;
    logic                            xfer;

    assign xfer = s_axis_tvalid && ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        ready_d   = ready_q;
        applied_d = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        wmask_d   = wmask_q;
        early_d   = early_q;
        miss_d    = miss_q;
        case (state_q)
            IDLE: begin
                applied_d = !apply;
                ready_d   = 1'b0;
                if (apply && cmdLoad) begin
                    mask_d  = loadMask;
                    cnt_d   = '0;
                    early_d = 1'b0;
                    miss_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: if (xfer) begin
                we_d    = 1'b1;
                addr_d  = cnt_q[MEM_ADDR_WIDTH-1:0];
                data_d  = s_axis_tdata;
                wmask_d = {PIXEL_PER_BEAT{mask_q}};
                cnt_d   = cnt_q + 1'b1;
                if (s_axis_tlast) begin
                    early_d = early_q | (cnt_q < LAST);
                    ready_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    // tready stays high so the rest of the oversized frame drains
                    miss_d  = 1'b1;
                    state_d = DISCARD;
                end
            end
            DISCARD: if (xfer && s_axis_tlast) begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            ready_q   <= 1'b0;
            applied_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wmask_q   <= '0;
            early_q   <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            ready_q   <= ready_d;
            applied_q <= applied_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wmask_q   <= wmask_d;
            early_q   <= early_d;
            miss_q    <= miss_d;
        end
    end

    assign applied         = applied_q;
    assign s_axis_tready   = ready_q;
    assign memWrite        = we_q;
    assign memWriteAddr    = addr_q;
    assign memWriteData    = data_q;
    assign memWriteMask    = wmask_q;
    assign errTlastEarly   = early_q;
    assign errTlastMissing = miss_q;
endmodule

// File: doc/fb_stream_loader.md
# fb_stream_loader

AXI-Stream slave that loads a complete frame into the framebuffer RAM; it is the receiving counterpart of the framebuffer commit stream. A host command starts a load via the apply/applied handshake. The block accepts exactly one frame of beats and writes each beat to consecutive RAM word addresses through a masked write port. It checks tlast framing and discards surplus beats after a framing error.

## Interface
Parameters:
- FRAME_SIZE, 128*128: pixels per frame.
- STREAM_WIDTH, 16: bits per beat and RAM word width.
- NUMBER_OF_SUB_PIXELS, 4: channels per pixel; width of the write mask.
- SUB_PIXEL_WIDTH, 4: bits per channel and RAM strobe granularity.
- Derived:
  - PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH
  - PIXEL_PER_BEAT = STREAM_WIDTH/PIXEL_WIDTH
  - BEATS = FRAME_SIZE/PIXEL_PER_BEAT
  - MEM_ADDR_WIDTH = $clog2(BEATS)
  - STROBES = STREAM_WIDTH/SUB_PIXEL_WIDTH

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- apply  in  1  command strobe; sampled only in IDLE.
- applied  out  1  1 = idle and ready for a command.
- cmdLoad  in  1  sampled with apply; 1 = load a frame.
- loadMask  in  NUMBER_OF_SUB_PIXELS  channel write mask; sampled with apply and held for the whole load.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept; registered.
- s_axis_tlast  in  1  last beat of the frame.
- s_axis_tdata  in  STREAM_WIDTH  beat payload.
- memWrite  out  1  RAM write enable.
- memWriteAddr  out  MEM_ADDR_WIDTH  RAM word address.
- memWriteData  out  STREAM_WIDTH  RAM write data.
- memWriteMask  out  STROBES  RAM strobes = {PIXEL_PER_BEAT{loadMask latched}}.
- errTlastEarly  out  1  sticky: tlast arrived before beat BEATS-1.
- errTlastMissing  out  1  sticky: no tlast on beat BEATS-1.

## Operation
- States: IDLE, LOAD, DISCARD.
- Handshake: a beat transfers on a clk edge with s_axis_tvalid && s_axis_tready. A beat counter (MEM_ADDR_WIDTH+1 bits wide) counts transfers from 0.
- IDLE:
  - s_axis_tready=0; applied<=!apply.
  - apply && cmdLoad: latch loadMask, clear counter and both error flags, set s_axis_tready<=1, go to LOAD.
  - apply && !cmdLoad: no-op; applied is 0 for one cycle, state stays IDLE, error flags unchanged.
- LOAD, on each transfer:
  - Register memWrite<=1, memWriteAddr<=counter, memWriteData<=tdata, memWriteMask<=replicated mask; counter++.
  - Cycles without a transfer: memWrite<=0.
  - tlast && counter<BEATS-1: write the beat, set errTlastEarly, tready<=0, go to IDLE.
  - counter==BEATS-1 && tlast: write the beat, tready<=0, go to IDLE.
  - counter==BEATS-1 && !tlast: write the beat, set errTlastMissing, keep tready=1, go to DISCARD.
- DISCARD:
  - Accept beats with tready=1, memWrite=0, no RAM update.
  - On a transfer with tlast: tready<=0, go to IDLE.
- Address arithmetic: memWriteAddr is the counter truncated to MEM_ADDR_WIDTH. Beats beyond BEATS are never written, so there is no wrap-around.
- Error flags hold until the next accepted load command or reset.

## Timing
- Reset values: applied=1, s_axis_tready=0, memWrite=0, memWriteAddr=0, memWriteData=0, memWriteMask=0, errTlastEarly=0, errTlastMissing=0; state IDLE.
- Reset mid-load: returns to IDLE on the same edge. No further writes occur; partially written RAM contents stay.
- Start latency:
  - apply sampled at edge E: applied=0 and tready=1 after E.
  - The first beat can transfer at E+1.
- Throughput: one beat per cycle. tready stays 1 continuously in LOAD/DISCARD; there is no RAM backpressure.
- Write latency: a beat transferred at edge T appears on the write port after T and is committed by the RAM at T+1.
- End of load:
  - Final beat transferred at edge T: tready=0 and state IDLE after T.
  - memWrite stays high through edge T+1 (last write).
  - applied=1 after T+1. A host seeing applied=1 is guaranteed all writes are committed.
- tvalid low in LOAD: nothing happens and the counter holds. There is no timeout.
- An apply asserted while not in IDLE is ignored.

## Test plan
Use FRAME_SIZE=16, STREAM_WIDTH=32, PIXEL_WIDTH=16 (2 pixels/beat, BEATS=8).
- Basic load: apply+cmdLoad, loadMask=4'hF; stream beats 0x00010000+k, k=0..7, tlast on k=7, tvalid always 1.
  - Writes go to addr 0..7 with data 0x00010000+k and memWriteMask=8'hFF on 8 consecutive cycles.
  - applied=1 two cycles after the final transfer; both error flags 0.
- Throttled source: same frame with tvalid toggling 1,0,0,1.
  - Exactly 8 writes at addr 0..7 in order, with no duplicate or skipped address.
- Masked load: loadMask=4'b0101.
  - memWriteMask=8'b01010101 on every write.
- Early tlast: tlast on k=4.
  - Writes at addr 0..4 only; errTlastEarly=1; applied=1; a later beat on the bus sees tready=0.
- Missing tlast: 11 beats, tlast on k=10.
  - Writes at addr 0..7 only; beats 8..10 are accepted but not written; errTlastMissing=1.
  - A following good load clears the flag.
- Reset after 3 beats:
  - All outputs return to reset values next cycle and there are no further writes.
  - A new apply+cmdLoad then loads a full frame normally.
